// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a small byte FIFO.
// Bytes queue on a valid/ready port; frames go out LSB first on o_tx.
module uart_tx_fifo #(
    parameter int TIMER_BITS      = 10,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int FIFO_AW         = 3
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy,
    output logic [FIFO_AW:0] o_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [FIFO_AW:0] FULL =
        (FIFO_AW + 1)'(DEPTH);

    localparam logic [TIMER_BITS-1:0] BAUD_RELOAD =
        TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_d;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [7:0]         head_byte;

    // Serialiser state
    state_t             state_q;
    state_t             state_d;
    logic [TIMER_BITS-1:0] baud_q;
    logic [TIMER_BITS-1:0] baud_d;
    logic               baud_done;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic [2:0]         idx_q;
    logic [2:0]         idx_d;
    logic               tx_q;
    logic               tx_d;

    assign o_ready       = (count_q != FULL);
    assign push          = i_valid && o_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head_byte     = mem_q[rd_ptr_q];
    assign baud_done     = (baud_q == '0);

    assign o_tx    = tx_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_count = count_q;

    // Byte storage; no reset needed, pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame sequencer: next state, baud timing, shifter and line value
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (baud_done) begin
            baud_d = baud_q;
        end else begin
            baud_d = baud_q - TIMER_BITS'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = head_byte;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_done) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    baud_d  = BAUD_RELOAD;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end

            S_STOP: begin
                if (baud_done) begin
                    if (fifo_nonempty) begin
                        // Back-to-back frame: no idle bit between stop and start
                        pop     = 1'b1;
                        shift_d = head_byte;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

endmodule
